// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with selectable bit order, frame resync,
// a valid/ready output register and a sticky overflow flag for dropped words.
module sipo_deser #(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             complete;
    logic             transfer;
    logic             ovf_set;

    // Bit order decides which end the shifter enters from.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted    = {shift_q[WIDTH-2:0], bit_in};
            assign first_word = {{(WIDTH-1){1'b0}}, bit_in};
        end else begin : g_lsb
            assign shifted    = {bit_in, shift_q[WIDTH-1:1]};
            assign first_word = {bit_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    assign complete = bit_valid && !frame_start && (cnt_q == LAST_IDX);
    assign transfer = valid_q && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_set = 1'b0;

        if (frame_start) begin
            shift_d = bit_valid ? first_word : '0;
            cnt_d   = bit_valid ? CW'(1) : '0;
        end else if (bit_valid) begin
            shift_d = shifted;
            cnt_d   = complete ? '0 : cnt_q + CW'(1);
        end

        if (complete && (!valid_q || transfer)) begin
            data_d  = shifted;
            valid_d = 1'b1;
        end else if (complete) begin
            ovf_set = 1'b1;
        end else if (transfer) begin
            valid_d = 1'b0;
        end

        // Overflow set beats a coincident clear so no drop goes unreported.
        ovf_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign bit_count = cnt_q;

endmodule
